// File: rtl/dmem_bytelane.sv
// dmem_bytelane
// ---------------------------------------------------------------------------
// Single-port data memory for the load/store stage. Supports byte-lane
// stores, sub-word loads with optional sign extension, a one-cycle
// request/response handshake and a background clear sweep that zeroes
// every word after reset.
//
// Parameters
//   ADDR_BITS : word-address width, depth = 2**ADDR_BITS words
//   DATA_BITS : word width, 32 or 64
//
// Ports
//   clk       : clock, everything on the rising edge
//   clr       : synchronous active-high reset; holds the sweep at index 0
//               and starts it on the first edge with clr low
//   req       : request valid
//   we        : 1 = store, 0 = load (sampled with req)
//   size      : 00 byte, 01 half, 10 word, 11 double (64-bit build only)
//   sext      : loads only, 1 = sign-extend the sub-word
//   addr      : byte address {word index, lane}
//   wdata     : right-aligned store data
//   busy      : clear sweep in progress, requests are dropped
//   rvalid    : one-cycle pulse, rdata carries a load result
//   rdata     : right-aligned, extended load result (held between loads)
//   err       : one-cycle pulse, accepted request was misaligned/illegal
//   state_dbg : current sweep FSM state (IDLE=0, HOLD=1, SWEEP=2)
//
// Handshake: a request is accepted on a rising edge where req=1, busy=0
// and clr=0. Its response (rvalid or err, never both) is visible during
// the following cycle. Stores respond with neither; they update the array
// on the accepting edge, so a load accepted on the next edge sees the data.
// ---------------------------------------------------------------------------
module dmem_bytelane #(
    parameter int ADDR_BITS = 10,
    parameter int DATA_BITS = 32,
    localparam int LANES     = DATA_BITS / 8,
    localparam int LANE_BITS = $clog2(DATA_BITS / 8),
    localparam int DEPTH     = 1 << ADDR_BITS
) (
    input  logic                           clk,
    input  logic                           clr,
    input  logic                           req,
    input  logic                           we,
    input  logic [1:0]                     size,
    input  logic                           sext,
    input  logic [ADDR_BITS+LANE_BITS-1:0] addr,
    input  logic [DATA_BITS-1:0]           wdata,
    output logic                           busy,
    output logic                           rvalid,
    output logic [DATA_BITS-1:0]           rdata,
    output logic                           err,
    output logic [1:0]                     state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HOLD  = 2'd1,
        ST_SWEEP = 2'd2
    } state_t;

    // Power-up values: array zero, FSM idle, outputs quiet.
    state_t                 state     = ST_IDLE;
    logic [ADDR_BITS-1:0]   sweep_idx = '0;
    logic                   busy_q    = 1'b0;
    logic                   rvalid_q  = 1'b0;
    logic                   err_q     = 1'b0;
    logic [DATA_BITS-1:0]   rdata_q   = '0;
    logic [DATA_BITS-1:0]   mem [DEPTH] = '{default: '0};

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [LANE_BITS-1:0]   lane;
    logic [ADDR_BITS-1:0]   word_sel;
    logic [LANE_BITS+2:0]   shamt;

    assign lane     = addr[LANE_BITS-1:0];
    assign word_sel = addr[LANE_BITS +: ADDR_BITS];
    assign shamt    = {lane, 3'b000};

    // ------------------------------------------------------------------
    // Legality, byte enables and data alignment
    // ------------------------------------------------------------------
    logic [3:0]             nbytes;
    logic [6:0]             nbits;
    logic [2:0]             lane3;
    logic [2:0]             amask;
    logic                   size_ok;
    logic                   align_ok;
    logic                   legal;
    logic [3:0]             lane_lo;
    logic [3:0]             lane_hi;
    logic [LANES-1:0]       be;
    logic [DATA_BITS-1:0]   wdata_sh;
    logic [DATA_BITS-1:0]   rd_word;
    logic [DATA_BITS-1:0]   rd_sh;
    logic [DATA_BITS-1:0]   keep;
    logic [DATA_BITS-1:0]   ld_ext;
    logic                   fill;

    always_comb begin
        nbytes   = 4'd1 << size;
        nbits    = {nbytes, 3'b000};
        lane3    = 3'(lane);
        amask    = 3'(nbytes - 4'd1);

        // Doubles only exist in the 64-bit build.
        size_ok  = (size != 2'b11) || (DATA_BITS == 64);
        // Natural alignment: the lane offset must be a multiple of the size.
        align_ok = (lane3 & amask) == 3'b000;
        legal    = size_ok && align_ok;

        // Lanes [lane, lane + nbytes) are written by a store.
        lane_lo  = 4'(lane);
        lane_hi  = lane_lo + nbytes;
        be       = '0;
        for (int l = 0; l < LANES; l++) begin
            be[l] = (4'(l) >= lane_lo) && (4'(l) < lane_hi);
        end

        wdata_sh = wdata << shamt;

        // Load path: bring the addressed lanes down to bit 0, then replace
        // everything above the access width with the fill bit.
        rd_word  = mem[word_sel];
        rd_sh    = rd_word >> shamt;
        fill     = 1'b0;
        case (size)
            2'b00:   fill = rd_sh[7];
            2'b01:   fill = rd_sh[15];
            2'b10:   fill = rd_sh[31];
            default: fill = rd_sh[DATA_BITS-1];
        endcase
        fill     = fill & sext;
        // A full-width access shifts every one out, so keep is all ones and
        // sext has no effect.
        keep     = ~({DATA_BITS{1'b1}} << nbits);
        ld_ext   = (rd_sh & keep) | (~keep & {DATA_BITS{fill}});
    end

    // ------------------------------------------------------------------
    // Request acceptance
    // ------------------------------------------------------------------
    // busy is registered, so a request is taken on the first edge where
    // the registered value is already low. clr always wins.
    logic accept;
    logic sweep_wr;

    assign accept   = req && !busy_q && !clr;
    assign sweep_wr = (state == ST_SWEEP) && !clr;

    // ------------------------------------------------------------------
    // Storage array (no reset: only the sweep clears it)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (sweep_wr) begin
            mem[sweep_idx] <= '0;
        end else if (accept && we && legal) begin
            for (int l = 0; l < LANES; l++) begin
                if (be[l]) begin
                    mem[word_sel][l*8 +: 8] <= wdata_sh[l*8 +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Sweep FSM and response registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_HOLD;
            sweep_idx <= '0;
            busy_q    <= 1'b1;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;

            case (state)
                ST_HOLD: begin
                    state  <= ST_SWEEP;
                    busy_q <= 1'b1;
                end
                ST_SWEEP: begin
                    sweep_idx <= sweep_idx + 1'b1;
                    // Leave the sweep on the edge that zeroes the last word.
                    if (&sweep_idx) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase

            // rdata only moves on a legal load; stores and errors leave it.
            if (accept) begin
                if (!legal) begin
                    err_q <= 1'b1;
                end else if (!we) begin
                    rvalid_q <= 1'b1;
                    rdata_q  <= ld_ext;
                end
            end
        end
    end

    assign busy      = busy_q;
    assign rvalid    = rvalid_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_dmem_bytelane.sv
// tb_dmem_bytelane
// Directed bench for dmem_bytelane with ADDR_BITS=4, DATA_BITS=32.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit
// after the rising edge that accepted a request.
module tb_dmem_bytelane;

  localparam int AB = 4;
  localparam int DB = 32;
  localparam int AW = AB + 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic clr;
  logic req;
  logic we;
  logic [1:0] size;
  logic sext;
  logic [AW-1:0] addr;
  logic [DB-1:0] wdata;
  wire busy;
  wire rvalid;
  wire [DB-1:0] rdata;
  wire err;
  wire [1:0] state_dbg;

  always #5 clk = ~clk;

  dmem_bytelane #(
    .ADDR_BITS(AB),
    .DATA_BITS(DB)
  ) dut (
    .clk(clk),
    .clr(clr),
    .req(req),
    .we(we),
    .size(size),
    .sext(sext),
    .addr(addr),
    .wdata(wdata),
    .busy(busy),
    .rvalid(rvalid),
    .rdata(rdata),
    .err(err),
    .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [DB-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic issue(input logic w, input logic [1:0] sz, input logic sx,
                       input logic [AW-1:0] a, input logic [DB-1:0] wd);
    @(negedge clk);
    req = 1'b1;
    we = w;
    size = sz;
    sext = sx;
    addr = a;
    wdata = wd;
    @(posedge clk);
    #1;
    req = 1'b0;
  endtask

  task automatic store(input string tag, input logic [1:0] sz,
                       input logic [AW-1:0] a, input logic [DB-1:0] wd);
    issue(1'b1, sz, 1'b0, a, wd);
    chk({tag, " rvalid"}, {31'b0, rvalid}, 32'd0);
    chk({tag, " err"}, {31'b0, err}, 32'd0);
  endtask

  task automatic load(input string tag, input logic [1:0] sz, input logic sx,
                      input logic [AW-1:0] a, input logic [DB-1:0] exp);
    exp_q.push_back(exp);
    issue(1'b0, sz, sx, a, '0);
    chk({tag, " rvalid"}, {31'b0, rvalid}, 32'd1);
    chk({tag, " err"}, {31'b0, err}, 32'd0);
    chk({tag, " rdata"}, rdata, exp_q.pop_front());
  endtask

  task automatic bad(input string tag, input logic w, input logic [1:0] sz,
                     input logic [AW-1:0] a, input logic [DB-1:0] prev);
    issue(w, sz, 1'b0, a, 32'h1234);
    chk({tag, " err"}, {31'b0, err}, 32'd1);
    chk({tag, " rvalid"}, {31'b0, rvalid}, 32'd0);
    chk({tag, " rdata kept"}, rdata, prev);
  endtask

  // Called with clr just dropped: counts post-edge samples with busy high
  // (bounded), and rvalid pulses seen along the way.
  task automatic measure_sweep(output int cnt, output int rv);
    bit done;
    cnt = 0;
    rv = 0;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(posedge clk);
      #1;
      if (rvalid) rv++;
      if (busy) cnt++;
      else done = 1'b1;
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int cnt;
    int rv;

    clr = 1'b1;
    req = 1'b0;
    we = 1'b0;
    size = 2'b00;
    sext = 1'b0;
    addr = '0;
    wdata = '0;

    #1;
    chk("pwrup busy", {31'b0, busy}, 32'd0);
    chk("pwrup rvalid", {31'b0, rvalid}, 32'd0);

    @(posedge clk);
    #1;
    chk("rst busy", {31'b0, busy}, 32'd1);
    chk("rst rvalid", {31'b0, rvalid}, 32'd0);
    chk("rst err", {31'b0, err}, 32'd0);
    chk("rst rdata", rdata, 32'd0);
    @(negedge clk);
    clr = 1'b0;
    measure_sweep(cnt, rv);
    chk("init sweep len", cnt, 32'd16);

    // ---- sweep timing: fill, 2-cycle clr, 16 busy cycles, all zero ----
    for (int i = 0; i < 16; i++) store("fill", 2'b10, AW'(i * 4), 32'hDEADBEEF);
    load("prefill w5", 2'b10, 1'b0, 6'h14, 32'hDEADBEEF);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("clr rdata", rdata, 32'd0);
    chk("clr rvalid", {31'b0, rvalid}, 32'd0);
    chk("clr busy", {31'b0, busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b0;
    measure_sweep(cnt, rv);
    chk("sweep len", cnt, 32'd16);
    chk("sweep rvalid", rv, 32'd0);
    for (int i = 0; i < 16; i++) load("swept", 2'b10, 1'b0, AW'(i * 4), 32'd0);

    // ---- byte lanes ----
    store("bl word", 2'b10, 6'h10, 32'h11223344);
    store("bl byte", 2'b00, 6'h12, 32'h000000AA);
    load("bl mid", 2'b10, 1'b0, 6'h10, 32'h11AA3344);
    store("bl half", 2'b01, 6'h10, 32'h0000BEEF);
    load("bl final", 2'b10, 1'b0, 6'h10, 32'h11AABEEF);
    store("bl byte3", 2'b00, 6'h17, 32'hFFFFFF5C);
    load("bl lane3", 2'b10, 1'b0, 6'h14, 32'h5C000000);

    // ---- sign extension ----
    store("sx word", 2'b10, 6'h20, 32'h0080FF7F);
    load("sx b21 s", 2'b00, 1'b1, 6'h21, 32'hFFFFFFFF);
    load("sx b21 z", 2'b00, 1'b0, 6'h21, 32'h000000FF);
    load("sx h22 s", 2'b01, 1'b1, 6'h22, 32'h00000080);
    load("sx h20 s", 2'b01, 1'b1, 6'h20, 32'hFFFFFF7F);
    load("sx h20 z", 2'b01, 1'b0, 6'h20, 32'h0000FF7F);
    load("sx b22 s", 2'b00, 1'b1, 6'h22, 32'hFFFFFF80);
    load("sx b20 s", 2'b00, 1'b1, 6'h20, 32'h0000007F);
    load("sx word s", 2'b10, 1'b1, 6'h20, 32'h0080FF7F);

    // ---- misaligned / illegal ----
    store("mis setup", 2'b10, 6'h30, 32'hCAFEF00D);
    load("mis prev", 2'b10, 1'b0, 6'h30, 32'hCAFEF00D);
    bad("mis half st", 1'b1, 2'b01, 6'h31, 32'hCAFEF00D);
    bad("mis word ld", 1'b0, 2'b10, 6'h32, 32'hCAFEF00D);
    bad("dbl ld", 1'b0, 2'b11, 6'h30, 32'hCAFEF00D);
    bad("dbl st", 1'b1, 2'b11, 6'h30, 32'hCAFEF00D);
    load("mis unchanged", 2'b10, 1'b0, 6'h30, 32'hCAFEF00D);

    // ---- pipeline: store then load back to back ----
    @(negedge clk);
    req = 1'b1;
    we = 1'b1;
    size = 2'b10;
    sext = 1'b0;
    addr = 6'h14;
    wdata = 32'h5A5A1234;
    @(negedge clk);
    chk("pipe st rvalid", {31'b0, rvalid}, 32'd0);
    we = 1'b0;
    @(negedge clk);
    chk("pipe ld rvalid", {31'b0, rvalid}, 32'd1);
    chk("pipe ld rdata", rdata, 32'h5A5A1234);
    addr = 6'h10;
    @(negedge clk);
    chk("pipe ld2 rvalid", {31'b0, rvalid}, 32'd1);
    chk("pipe ld2 rdata", rdata, 32'h11AABEEF);
    req = 1'b0;
    @(negedge clk);
    chk("pipe idle rvalid", {31'b0, rvalid}, 32'd0);
    chk("pipe idle rdata", rdata, 32'h11AABEEF);

    // ---- mid-sweep reset with req held throughout ----
    for (int i = 0; i < 16; i++) store("fill2", 2'b10, AW'(i * 4), 32'h01010101 * (i + 1));
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    req = 1'b1;
    we = 1'b0;
    size = 2'b10;
    sext = 1'b0;
    addr = 6'h00;
    rv = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      if (rvalid) rv++;
      if (!busy) rv += 100;
    end
    chk("mid pre busy/rvalid", rv, 32'd0);
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1;
    chk("mid clr busy", {31'b0, busy}, 32'd1);
    @(negedge clk);
    clr = 1'b0;
    measure_sweep(cnt, rv);
    chk("mid sweep len", cnt, 32'd16);
    chk("mid held req rvalid", rv, 32'd0);
    @(posedge clk);
    #1;
    chk("mid first accept rvalid", {31'b0, rvalid}, 32'd1);
    chk("mid first accept rdata", rdata, 32'd0);
    req = 1'b0;
    for (int i = 0; i < 16; i++) load("mid swept", 2'b10, 1'b0, AW'(i * 4), 32'd0);

    // ---- final report ----
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

endmodule
